// File: rtl/sram22_pkg.sv
// Shared definitions for the sram22 parametrised RAM model.
//   state_e     : power-on clear sequencer states
//   RL_MIN/MAX  : legal range of the read latency
//   lane_width  : bits per write-mask lane
package sram22_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    localparam int RL_MIN = 1;
    localparam int RL_MAX = 2;

    function automatic int lane_width(input int data_w, input int lanes);
        return data_w / lanes;
    endfunction

endpackage

// File: rtl/sram22_clear_seq.sv
// Power-on clear sequencer for sram22_param_ram.
// Walks every address once after reset, requesting a zero write for each,
// then parks in RUN and raises ready one cycle later.
//   clk      in   clock
//   rstb     in   synchronous active-low reset
//   ready    out  requests may be accepted (registered from state)
//   clr_we   out  zero-write request for clr_addr this cycle
//   clr_addr out  address being cleared
module sram22_clear_seq
    import sram22_pkg::*;
#(
    parameter int ADDR_WIDTH     = 7,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rstb,
    output logic                  ready,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
    logic                  ready_q, ready_d;

    // State register
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q    <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
            clr_addr_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            ready_q    <= ready_d;
        end
    end

    // Next state: the edge that clears the last address leaves CLEAR
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        if (state_q == CLEAR) begin
            clr_addr_d = clr_addr_q + 1'b1;
            if (clr_addr_q == '1) begin
                state_d = RUN;
            end
        end
    end

    // Outputs
    always_comb begin
        clr_we   = rstb && (state_q == CLEAR);
        clr_addr = clr_addr_q;
        ready_d  = (state_q == RUN);
        ready    = ready_q;
    end

endmodule

// File: rtl/sram22_param_ram.sv
// Parametrised behavioural model of the sram22 single-port macro family.
// Masked lane writes, 1- or 2-cycle registered reads with a valid strobe,
// and an optional zeroing pass after reset that holds off requests.
//   clk        in   clock
//   rstb       in   synchronous active-low reset
//   ce         in   chip enable
//   we         in   1 = write, 0 = read
//   wmask      in   per-lane write enable
//   addr       in   word address
//   din        in   write data
//   dout       out  read data, held between reads
//   dout_valid out  one-cycle pulse with each completed read
//   ready      out  requests accepted
module sram22_param_ram
    import sram22_pkg::*;
#(
    parameter int DATA_WIDTH     = 24,
    parameter int ADDR_WIDTH     = 7,
    parameter int WMASK_WIDTH    = 3,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                   clk,
    input  logic                   rstb,
    input  logic                   ce,
    input  logic                   we,
    input  logic [WMASK_WIDTH-1:0] wmask,
    input  logic [ADDR_WIDTH-1:0]  addr,
    input  logic [DATA_WIDTH-1:0]  din,
    output logic [DATA_WIDTH-1:0]  dout,
    output logic                   dout_valid,
    output logic                   ready
);

    localparam int LW        = lane_width(DATA_WIDTH, WMASK_WIDTH);
    localparam int RAM_DEPTH = 2 ** ADDR_WIDTH;

    if (DATA_WIDTH % WMASK_WIDTH != 0) begin : g_chk_mask
        $fatal(1, "sram22_param_ram: DATA_WIDTH must be a multiple of WMASK_WIDTH");
    end
    if (READ_LATENCY < RL_MIN || READ_LATENCY > RL_MAX) begin : g_chk_rl
        $fatal(1, "sram22_param_ram: READ_LATENCY must be 1 or 2");
    end

    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;

    sram22_clear_seq #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .CLEAR_ON_RESET(CLEAR_ON_RESET)
    ) u_clear_seq (
        .clk     (clk),
        .rstb    (rstb),
        .ready   (ready),
        .clr_we  (clr_we),
        .clr_addr(clr_addr)
    );

    logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];
    logic                  mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_waddr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_d;
    logic                  wr_en, rd_en;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  dout_valid_q, dout_valid_d;

    // ready is low during the clear pass, so clear and user writes never collide
    assign wr_en   = ready && ce && we;
    assign rd_en   = ready && ce && !we;
    assign rd_word = mem_q[addr];

    // Write port: merge the enabled lanes over the current word
    always_comb begin
        mem_we_d    = 1'b0;
        mem_waddr_d = addr;
        mem_wdata_d = mem_q[addr];
        if (clr_we) begin
            mem_we_d    = 1'b1;
            mem_waddr_d = clr_addr;
            mem_wdata_d = '0;
        end else if (wr_en) begin
            mem_we_d = 1'b1;
            for (int i = 0; i < WMASK_WIDTH; i++) begin
                if (wmask[i]) begin
                    mem_wdata_d[i*LW +: LW] = din[i*LW +: LW];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we_d) begin
            mem_q[mem_waddr_d] <= mem_wdata_d;
        end
    end

    if (READ_LATENCY == 1) begin : g_rl1
        // Stage p1: array word straight to dout
        always_comb begin
            dout_valid_d = rd_en;
            dout_d       = rd_en ? rd_word : dout_q;
        end
    end else begin : g_rl2
        logic [DATA_WIDTH-1:0] rd_data_p1_q, rd_data_p1_d;
        logic                  vld_p1_q, vld_p1_d;

        // Stage p1: capture array word
        always_comb begin
            vld_p1_d     = rd_en;
            rd_data_p1_d = rd_en ? rd_word : rd_data_p1_q;
        end

        always_ff @(posedge clk) begin
            if (!rstb) begin
                rd_data_p1_q <= '0;
                vld_p1_q     <= 1'b0;
            end else begin
                rd_data_p1_q <= rd_data_p1_d;
                vld_p1_q     <= vld_p1_d;
            end
        end

        // Stage p2: p1 to dout
        always_comb begin
            dout_valid_d = vld_p1_q;
            dout_d       = vld_p1_q ? rd_data_p1_q : dout_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_sram22_param_ram.sv
// Testbench for sram22_param_ram. Three instances share one clock:
//   0: defaults (24b x 128, 3 lanes, latency 1, clear on reset)
//   1: defaults with latency 2
//   2: 32b x 16, 4 lanes, latency 1, no clear
// A word-level reference model tracks array contents, readiness and the
// read result stream of each instance.
module tb_sram22_param_ram;

    localparam int N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        in_rstb [N];
    logic        in_ce   [N];
    logic        in_we   [N];
    logic [3:0]  in_mask [N];
    logic [6:0]  in_addr [N];
    logic [31:0] in_din  [N];

    logic [23:0] a_dout, b_dout;
    logic [31:0] c_dout;
    logic        a_vld, b_vld, c_vld, a_rdy, b_rdy, c_rdy;
    logic [31:0] dut_dout  [N];
    logic        dut_vld   [N];
    logic        dut_ready [N];

    always_comb begin
        dut_dout[0]  = {8'h00, a_dout};
        dut_dout[1]  = {8'h00, b_dout};
        dut_dout[2]  = c_dout;
        dut_vld[0]   = a_vld;
        dut_vld[1]   = b_vld;
        dut_vld[2]   = c_vld;
        dut_ready[0] = a_rdy;
        dut_ready[1] = b_rdy;
        dut_ready[2] = c_rdy;
    end

    sram22_param_ram #(.DATA_WIDTH(24), .ADDR_WIDTH(7), .WMASK_WIDTH(3),
                       .READ_LATENCY(1), .CLEAR_ON_RESET(1)) u_a (
        .clk(clk), .rstb(in_rstb[0]), .ce(in_ce[0]), .we(in_we[0]),
        .wmask(in_mask[0][2:0]), .addr(in_addr[0]), .din(in_din[0][23:0]),
        .dout(a_dout), .dout_valid(a_vld), .ready(a_rdy));

    sram22_param_ram #(.DATA_WIDTH(24), .ADDR_WIDTH(7), .WMASK_WIDTH(3),
                       .READ_LATENCY(2), .CLEAR_ON_RESET(1)) u_b (
        .clk(clk), .rstb(in_rstb[1]), .ce(in_ce[1]), .we(in_we[1]),
        .wmask(in_mask[1][2:0]), .addr(in_addr[1]), .din(in_din[1][23:0]),
        .dout(b_dout), .dout_valid(b_vld), .ready(b_rdy));

    sram22_param_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .WMASK_WIDTH(4),
                       .READ_LATENCY(1), .CLEAR_ON_RESET(0)) u_c (
        .clk(clk), .rstb(in_rstb[2]), .ce(in_ce[2]), .we(in_we[2]),
        .wmask(in_mask[2]), .addr(in_addr[2][3:0]), .din(in_din[2]),
        .dout(c_dout), .dout_valid(c_vld), .ready(c_rdy));

    // Per-instance configuration seen by the model
    int depth [N] = '{128, 128, 16};
    int lanes [N] = '{3, 3, 4};
    int rl    [N] = '{1, 2, 1};
    int clr   [N] = '{1, 1, 0};

    // Reference model state; m_km marks bits whose content is defined
    logic [31:0] m_mem  [N][128];
    logic [31:0] m_km   [N][128];
    int          up     [N];
    logic        m_ready[N];
    logic        m_vld  [N];
    logic [31:0] m_dout [N];
    logic [31:0] m_dk   [N];
    logic        p_vld  [N];
    logic [31:0] p_data [N];
    logic [31:0] p_k    [N];

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    task automatic model_edge(int i);
        logic        acc;
        logic [31:0] rd_d, rd_k;
        int          a;
        if (!in_rstb[i]) begin
            up[i] = 0; m_ready[i] = 1'b0; m_vld[i] = 1'b0;
            m_dout[i] = '0; m_dk[i] = '1; p_vld[i] = 1'b0;
            return;
        end
        a    = int'(in_addr[i]) % depth[i];
        acc  = m_ready[i] && in_ce[i];
        rd_d = m_mem[i][a];
        rd_k = m_km[i][a];
        if (acc && in_we[i]) begin
            for (int l = 0; l < lanes[i]; l++) begin
                if (in_mask[i][l]) begin
                    m_mem[i][a][l*8 +: 8] = in_din[i][l*8 +: 8];
                    m_km[i][a][l*8 +: 8]  = 8'hFF;
                end
            end
        end
        if (up[i] < 100000) up[i]++;
        // the whole array is zero once DEPTH clearing edges have elapsed
        if (clr[i] != 0 && up[i] == depth[i]) begin
            for (int k = 0; k < depth[i]; k++) begin
                m_mem[i][k] = '0;
                m_km[i][k]  = '1;
            end
        end
        m_ready[i] = (clr[i] != 0) ? (up[i] >= depth[i] + 1) : 1'b1;
        if (rl[i] == 1) begin
            m_vld[i] = acc && !in_we[i];
            if (m_vld[i]) begin m_dout[i] = rd_d; m_dk[i] = rd_k; end
        end else begin
            m_vld[i] = p_vld[i];
            if (p_vld[i]) begin m_dout[i] = p_data[i]; m_dk[i] = p_k[i]; end
            p_vld[i]  = acc && !in_we[i];
            p_data[i] = rd_d;
            p_k[i]    = rd_k;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < N; i++) model_edge(i);
        #1;
        cycle++;
    endtask

    task automatic drive(int i, logic ce, logic we, logic [3:0] m, logic [6:0] a, logic [31:0] d);
        in_ce[i] = ce; in_we[i] = we; in_mask[i] = m; in_addr[i] = a; in_din[i] = d;
    endtask

    task automatic test_reset();
        for (int i = 0; i < N; i++) begin
            in_rstb[i] = 1'b0;
            drive(i, 1'b0, 1'b0, 4'h0, 7'h0, 32'h0);
        end
        tick();
        tick();
        for (int i = 0; i < N; i++) begin
            checks++;
            if (dut_ready[i] !== 1'b0) begin
                failures++; $display("FAIL reset_ready[%0d] got=%b exp=0", i, dut_ready[i]);
            end
            checks++;
            if (dut_vld[i] !== 1'b0) begin
                failures++; $display("FAIL reset_valid[%0d] got=%b exp=0", i, dut_vld[i]);
            end
            checks++;
            if (dut_dout[i] !== 32'h0) begin
                failures++; $display("FAIL reset_dout[%0d] got=%h exp=0", i, dut_dout[i]);
            end
        end
        for (int i = 0; i < N; i++) in_rstb[i] = 1'b1;
    endtask

    task automatic test_clear();
        int rise [N] = '{-1, -1, -1};
        for (int cyc = 1; cyc <= 140; cyc++) begin
            for (int i = 0; i < N; i++)
                drive(i, 1'b1, 1'b0, 4'h0, 7'($urandom_range(0, depth[i] - 1)), 32'h0);
            tick();
            for (int i = 0; i < N; i++) begin
                if (rise[i] < 0 && dut_ready[i] === 1'b1) rise[i] = cyc;
                checks++;
                if (dut_ready[i] !== m_ready[i]) begin
                    failures++; $display("FAIL clear_ready[%0d] cyc=%0d got=%b exp=%b", i, cyc, dut_ready[i], m_ready[i]);
                end
                checks++;
                if (dut_vld[i] !== m_vld[i]) begin
                    failures++; $display("FAIL clear_valid[%0d] cyc=%0d got=%b exp=%b", i, cyc, dut_vld[i], m_vld[i]);
                end
                checks++;
                if (((dut_dout[i] ^ m_dout[i]) & m_dk[i]) !== 32'h0) begin
                    failures++; $display("FAIL clear_dout[%0d] cyc=%0d got=%h exp=%h", i, cyc, dut_dout[i], m_dout[i]);
                end
            end
        end
        checks++;
        if (rise[0] != 129) begin
            failures++; $display("FAIL clear_rise_a got=%0d exp=129", rise[0]);
        end
        checks++;
        if (rise[1] != 129) begin
            failures++; $display("FAIL clear_rise_b got=%0d exp=129", rise[1]);
        end
        checks++;
        if (rise[2] != 1) begin
            failures++; $display("FAIL clear_rise_c got=%0d exp=1", rise[2]);
        end
        for (int i = 0; i < N; i++) drive(i, 1'b0, 1'b0, 4'h0, 7'h0, 32'h0);
    endtask

    task automatic test_masked_write();
        drive(0, 1'b1, 1'b1, 4'b0111, 7'd5, 32'h00AABBCC); tick();
        drive(0, 1'b1, 1'b1, 4'b0010, 7'd5, 32'h00112233); tick();
        drive(0, 1'b1, 1'b0, 4'b0000, 7'd5, 32'h0);        tick();
        checks++;
        if (a_vld !== 1'b1 || a_dout !== 24'hAA22CC) begin
            failures++; $display("FAIL masked_read got=%b/%h exp=1/aa22cc", a_vld, a_dout);
        end
        drive(0, 1'b0, 1'b0, 4'h0, 7'h0, 32'h0); tick();
        checks++;
        if (a_vld !== 1'b0 || a_dout !== 24'hAA22CC) begin
            failures++; $display("FAIL masked_hold got=%b/%h exp=0/aa22cc", a_vld, a_dout);
        end
    endtask

    task automatic test_latency2();
        logic [23:0] v [3];
        for (int k = 0; k < 3; k++) begin
            v[k] = 24'($urandom);
            v[k][1:0] = 2'(k);
            drive(1, 1'b1, 1'b1, 4'b0111, 7'(k + 1), {8'h0, v[k]});
            tick();
        end
        drive(1, 1'b1, 1'b0, 4'h0, 7'd1, 32'h0); tick();
        checks++;
        if (b_vld !== 1'b0) begin
            failures++; $display("FAIL lat2_early got=%b exp=0", b_vld);
        end
        drive(1, 1'b1, 1'b0, 4'h0, 7'd2, 32'h0); tick();
        checks++;
        if (b_vld !== 1'b1 || b_dout !== v[0]) begin
            failures++; $display("FAIL lat2_first got=%b/%h exp=1/%h", b_vld, b_dout, v[0]);
        end
        drive(1, 1'b1, 1'b0, 4'h0, 7'd3, 32'h0); tick();
        checks++;
        if (b_vld !== 1'b1 || b_dout !== v[1]) begin
            failures++; $display("FAIL lat2_second got=%b/%h exp=1/%h", b_vld, b_dout, v[1]);
        end
        drive(1, 1'b0, 1'b0, 4'h0, 7'h0, 32'h0); tick();
        checks++;
        if (b_vld !== 1'b1 || b_dout !== v[2]) begin
            failures++; $display("FAIL lat2_third got=%b/%h exp=1/%h", b_vld, b_dout, v[2]);
        end
        tick();
        checks++;
        if (b_vld !== 1'b0 || b_dout !== v[2]) begin
            failures++; $display("FAIL lat2_hold got=%b/%h exp=0/%h", b_vld, b_dout, v[2]);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        // latency-2 read in flight when reset hits
        drive(1, 1'b1, 1'b0, 4'h0, 7'd2, 32'h0); tick();
        in_rstb[1] = 1'b0;
        drive(1, 1'b0, 1'b0, 4'h0, 7'h0, 32'h0); tick();
        checks++;
        if (b_vld !== 1'b0 || b_dout !== 24'h0) begin
            failures++; $display("FAIL inflight_drop got=%b/%h exp=0/000000", b_vld, b_dout);
        end
        in_rstb[1] = 1'b1;
        // reset 60 cycles into a clear pass
        in_rstb[0] = 1'b0; tick(); in_rstb[0] = 1'b1;
        for (int c = 0; c < 60; c++) begin
            drive(0, 1'b1, 1'($urandom_range(0, 1)), 4'b0111, 7'($urandom_range(0, 127)), $urandom);
            tick();
        end
        checks++;
        if (a_rdy !== 1'b0 || a_vld !== 1'b0) begin
            failures++; $display("FAIL midclear_busy got=%b/%b exp=0/0", a_rdy, a_vld);
        end
        in_rstb[0] = 1'b0; tick(); in_rstb[0] = 1'b1;
        n = 0;
        while (a_rdy !== 1'b1 && n < 300) begin
            drive(0, 1'b1, 1'b0, 4'h0, 7'($urandom_range(0, 127)), 32'h0);
            tick();
            n++;
            if (a_rdy !== 1'b1) begin
                checks++;
                if (a_vld !== 1'b0) begin
                    failures++; $display("FAIL midclear_drop cyc=%0d got=%b exp=0", n, a_vld);
                end
            end
        end
        checks++;
        if (n != 129) begin
            failures++; $display("FAIL midclear_restart got=%0d exp=129", n);
        end
        drive(0, 1'b0, 1'b0, 4'h0, 7'h0, 32'h0);
    endtask

    task automatic test_clear_off();
        drive(2, 1'b1, 1'b1, 4'b1001, 7'd15, 32'hDEADBEEF); tick();
        drive(2, 1'b1, 1'b0, 4'h0, 7'd15, 32'h0);         tick();
        checks++;
        if (c_vld !== 1'b1 || c_dout[31:24] !== 8'hDE || c_dout[7:0] !== 8'hEF) begin
            failures++; $display("FAIL nocl_lanes got=%b/%h exp=1/dexxxxef", c_vld, c_dout);
        end
        drive(2, 1'b0, 1'b0, 4'h0, 7'h0, 32'h0); tick();
    endtask

    task automatic test_wmask_zero();
        logic [31:0] x;
        x = $urandom;
        drive(0, 1'b1, 1'b1, 4'b0111, 7'd7, x);  drive(2, 1'b1, 1'b1, 4'b1111, 7'd7, x);  tick();
        drive(0, 1'b1, 1'b1, 4'b0000, 7'd7, ~x); drive(2, 1'b1, 1'b1, 4'b0000, 7'd7, ~x); tick();
        drive(0, 1'b1, 1'b0, 4'h0, 7'd7, 32'h0); drive(2, 1'b1, 1'b0, 4'h0, 7'd7, 32'h0); tick();
        checks++;
        if (a_vld !== 1'b1 || a_dout !== x[23:0]) begin
            failures++; $display("FAIL wmask0_a got=%b/%h exp=1/%h", a_vld, a_dout, x[23:0]);
        end
        checks++;
        if (c_vld !== 1'b1 || c_dout !== x) begin
            failures++; $display("FAIL wmask0_c got=%b/%h exp=1/%h", c_vld, c_dout, x);
        end
        drive(0, 1'b0, 1'b0, 4'h0, 7'h0, 32'h0); drive(2, 1'b0, 1'b0, 4'h0, 7'h0, 32'h0);
    endtask

    task automatic test_back_to_back();
        logic [23:0] v [4];
        for (int k = 0; k < 4; k++) begin
            v[k] = 24'($urandom);
            v[k][1:0] = 2'(k);
            drive(0, 1'b1, 1'b1, 4'b0111, 7'(10 + k), {8'h0, v[k]});
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            drive(0, 1'b1, 1'b0, 4'h0, 7'(10 + k), 32'h0);
            tick();
            checks++;
            if (a_vld !== 1'b1 || a_dout !== v[k]) begin
                failures++; $display("FAIL b2b_read%0d got=%b/%h exp=1/%h", k, a_vld, a_dout, v[k]);
            end
        end
        drive(0, 1'b0, 1'b0, 4'h0, 7'h0, 32'h0);
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < N; i++)
                drive(i, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                      4'($urandom), 7'($urandom_range(0, depth[i] - 1)), $urandom);
            tick();
            for (int i = 0; i < N; i++) begin
                checks++;
                if (dut_ready[i] !== m_ready[i]) begin
                    failures++; $display("FAIL rand_ready[%0d] cyc=%0d got=%b exp=%b", i, cyc, dut_ready[i], m_ready[i]);
                end
                checks++;
                if (dut_vld[i] !== m_vld[i]) begin
                    failures++; $display("FAIL rand_valid[%0d] cyc=%0d got=%b exp=%b", i, cyc, dut_vld[i], m_vld[i]);
                end
                checks++;
                if (((dut_dout[i] ^ m_dout[i]) & m_dk[i]) !== 32'h0) begin
                    failures++; $display("FAIL rand_dout[%0d] cyc=%0d got=%h exp=%h", i, cyc, dut_dout[i], m_dout[i]);
                end
            end
        end
        for (int i = 0; i < N; i++) drive(i, 1'b0, 1'b0, 4'h0, 7'h0, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            in_rstb[i] = 1'b0;
            drive(i, 1'b0, 1'b0, 4'h0, 7'h0, 32'h0);
            up[i] = 0; m_ready[i] = 1'b0; m_vld[i] = 1'b0;
            m_dout[i] = '0; m_dk[i] = '0; p_vld[i] = 1'b0;
            p_data[i] = '0; p_k[i] = '0;
            for (int k = 0; k < 128; k++) begin
                m_mem[i][k] = '0;
                m_km[i][k]  = '0;
            end
        end
        test_reset();
        test_clear();
        test_masked_write();
        test_latency2();
        test_reset_mid();
        test_clear_off();
        test_wmask_zero();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog cycle=%0d limit reached", cycle);
        $fatal(1, "watchdog");
    end

endmodule
